// File: rtl/aes_pkg.sv
// Shared AES types, S-box tables and the engine FSM encoding.
// Tables are stored MSB-first so SBOX[x] is the FIPS-197 entry for x.
package aes_pkg;

  typedef logic [7:0] aes_byte_t;
  // Byte 0 sits in bits [127:120], matching the external state layout.
  typedef logic [0:15][7:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } eng_state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic aes_byte_t sub_byte(
    input aes_byte_t b,
    input logic      inv
  );
    return inv ? INV_SBOX[b] : SBOX[b];
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lane: forward or inverse byte lookup.
module sbox_lane
  import aes_pkg::*;
(
  input  aes_byte_t in_byte,
  input  logic      inv,
  output aes_byte_t out_byte
);

  assign out_byte = sub_byte(in_byte, inv);

endmodule

// File: rtl/sub_bytes_engine.sv
// Multi-beat SubBytes/InvSubBytes engine, LANES bytes per cycle,
// valid/ready on both sides.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int BEATS = 16 / LANES;
  localparam logic [3:0] LAST = 4'(BEATS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
        LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  eng_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       inv_q, inv_d;
  aes_state_t work_q, work_d;

  aes_byte_t lane_in  [LANES];
  aes_byte_t lane_out [LANES];
  logic      accept;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    sbox_lane u_lane (
      .in_byte  (lane_in[j]),
      .inv      (inv_q),
      .out_byte (lane_out[j])
    );
  end

  // Lane j in beat k owns byte k*LANES+j.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_in[j] = work_q[4'(int'(cnt_q) * LANES + j)];
    end
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    inv_d    = inv_q;
    work_d   = work_q;
    in_ready = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        in_ready = rst_n;
      end
      (state_q == BUSY): begin
        for (int j = 0; j < LANES; j++) begin
          work_d[4'(int'(cnt_q) * LANES + j)] = lane_out[j];
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) state_d = DONE;
      end
      (state_q == DONE): begin
        // Ready passes straight through so a new block can
        // enter on the same edge the finished one leaves.
        in_ready = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (accept) begin
      work_d  = in_state;
      inv_d   = in_inv;
      cnt_d   = 4'd0;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      inv_q   <= 1'b0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      work_q  <= work_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_state = work_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: FIPS-197 vectors,
// handshake timing, backpressure, lane sweep and reset.
module tb_sub_bytes_engine;

  localparam logic [127:0] FWD_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FWD_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] A_IN    = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] A_OUT   = 128'h49ded28945db96f17f39871a7702533b;
  localparam logic [127:0] B_IN    = 128'haa8f5f0361dde3ef82d24ad26832469a;
  localparam logic [127:0] B_OUT   = 128'hac73cf7befc111df13b5d6b545235ab8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         in_inv = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic         busy;

  logic [3:0]   sw_valid = 4'h0;
  logic [3:0]   sw_rdy;
  logic [3:0]   sw_oval;
  logic [3:0]   sw_ordy = 4'h0;
  logic [3:0]   sw_busy;
  logic [127:0] sw_state = '0;
  logic [127:0] sw_out [4];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sub_bytes_engine #(.LANES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int LV = (g < 2) ? (1 << g) : (1 << (g + 1));
    sub_bytes_engine #(.LANES(LV)) u_sw (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sw_valid[g]),
      .in_ready  (sw_rdy[g]),
      .in_state  (sw_state),
      .in_inv    (1'b0),
      .out_valid (sw_oval[g]),
      .out_ready (sw_ordy[g]),
      .out_state (sw_out[g]),
      .busy      (sw_busy[g])
    );
  end

  task automatic test_reset();
    #1;
    total += 4;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid);
    end
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy got=%b exp=0", busy);
    end
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready);
    end
    if (out_state !== 128'h0) begin
      bad++; $display("FAIL rst_out_state got=%h exp=0", out_state);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_release_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_forward();
    in_state = FWD_IN; in_inv = 1'b0; in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_state = '1; in_inv = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      total += 2;
      if (out_valid !== (k == 4)) begin
        bad++;
        $display("FAIL fwd_lat_valid k=%0d got=%b exp=%b",
                 k, out_valid, (k == 4));
      end
      if (busy !== (k != 4)) begin
        bad++;
        $display("FAIL fwd_lat_busy k=%0d got=%b exp=%b",
                 k, busy, (k != 4));
      end
    end
    total += 2;
    if (out_state !== FWD_OUT) begin
      bad++;
      $display("FAIL fwd_state got=%h exp=%h", out_state, FWD_OUT);
    end
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL fwd_done_ready got=%b exp=0", in_ready);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL fwd_passthru got=%b exp=1", in_ready);
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL fwd_idle got v=%b b=%b exp v=0 b=0",
               out_valid, busy);
    end
    in_inv = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_state = A_IN; in_inv = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_state = B_IN;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL b2b_busy k=%0d got r=%b b=%b exp r=0 b=1",
                 k, in_ready, busy);
      end
    end
    @(posedge clk); #1;
    total += 2;
    if (out_valid !== 1'b1 || out_state !== A_OUT) begin
      bad++;
      $display("FAIL b2b_first got v=%b s=%h exp v=1 s=%h",
               out_valid, out_state, A_OUT);
    end
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_ready got=%b exp=1", in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_reaccept got b=%b v=%b exp b=1 v=0",
               busy, out_valid);
    end
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) @(posedge clk);
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out_state !== B_OUT) begin
      bad++;
      $display("FAIL b2b_second got v=%b s=%h exp v=1 s=%h",
               out_valid, out_state, B_OUT);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_idle got v=%b b=%b r=%b exp 0 0 1",
               out_valid, busy, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_inverse();
    in_state = FWD_OUT; in_inv = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; in_inv = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b1 || out_state !== FWD_IN) begin
      bad++;
      $display("FAIL inv_state got v=%b s=%h exp v=1 s=%h",
               out_valid, out_state, FWD_IN);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    in_state = FWD_IN; in_inv = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 in_state = FWD_OUT; in_inv = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_state !== FWD_OUT ||
          in_ready !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold c=%0d got v=%b r=%b b=%b s=%h exp v=1 r=0 b=0 s=%h",
                 c, out_valid, in_ready, busy, out_state, FWD_OUT);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_accept got b=%b v=%b exp b=1 v=0",
               busy, out_valid);
    end
    in_valid = 1'b0; out_ready = 1'b0; in_inv = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b1 || out_state !== FWD_IN) begin
      bad++;
      $display("FAIL bp_second got v=%b s=%h exp v=1 s=%h",
               out_valid, out_state, FWD_IN);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_lane_sweep();
    int lat [4];
    int exp_lat [4];
    exp_lat = '{16, 8, 2, 1};
    lat = '{-1, -1, -1, -1};
    sw_state = FWD_IN;
    sw_valid = 4'hf;
    total++;
    if (sw_rdy !== 4'hf) begin
      bad++; $display("FAIL sweep_ready got=%b exp=1111", sw_rdy);
    end
    @(posedge clk);
    #1 sw_valid = 4'h0;
    sw_state = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++) begin
        if (sw_oval[g] && lat[g] < 0) lat[g] = c;
      end
    end
    for (int g = 0; g < 4; g++) begin
      total += 2;
      if (lat[g] != exp_lat[g]) begin
        bad++;
        $display("FAIL sweep_lat inst=%0d got=%0d exp=%0d",
                 g, lat[g], exp_lat[g]);
      end
      if (sw_out[g] !== FWD_OUT) begin
        bad++;
        $display("FAIL sweep_state inst=%0d got=%h exp=%h",
                 g, sw_out[g], FWD_OUT);
      end
    end
    sw_ordy = 4'hf;
    @(posedge clk);
    #1 sw_ordy = 4'h0;
  endtask

  task automatic test_reset_mid();
    in_state = A_IN; in_inv = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 ||
        out_state !== 128'h0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst got v=%b b=%b r=%b s=%h exp 0 0 0 0",
               out_valid, busy, in_ready, out_state);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_release got r=%b b=%b exp r=1 b=0",
               in_ready, busy);
    end
    in_state = B_IN; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b1 || out_state !== B_OUT) begin
      bad++;
      $display("FAIL midrst_next got v=%b s=%h exp v=1 s=%h",
               out_valid, out_state, B_OUT);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_back_to_back();
    test_inverse();
    test_backpressure();
    test_lane_sweep();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
